fibonacci_checker: RTL

- Consumer and checker for the Fibonacci generators' output streams.
- Accepts samples over a valid/ready handshake, one or two per beat, and checks each accepted sample against the recurrence x[n] = x[n-1] + x[n-2] mod 2^W.
- Tracks lock state, counts matches and errors, and can halt intake on the first error until software clears it.
- Sits downstream of the single-rate or double-rate generator in test and self-check datapaths.

---
 rtl/fibonacci_checker_if.sv | 14 +
 rtl/fibonacci_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fibonacci_checker_if.sv
// Sample stream handshake between a Fibonacci generator and the checker.
// in_a carries the only (or earlier) sample of a beat; in_b the later one in dual-rate mode.
// A beat transfers when in_valid && in_ready.
interface fibonacci_checker_if #(
  parameter int W = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/fibonacci_checker.sv
// Checks a Fibonacci sample stream (1 or 2 samples/beat) against x[n]=x[n-1]+x[n-2] mod 2^W.
// Flags and counters are registered: visible the cycle after the transfer.
// in_ready is a pure register (halt flag); an error with halt_on_err=1 stalls intake until clear.
// Optional: FIB_CHECK_STRICT_SEED_EN forces seeding from EMPTY to be the samples 1, 1.
module fibonacci_checker #(
  parameter int W    = 16,
  parameter int DUAL = 0,
  parameter int CW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  fibonacci_checker_if.slave sink,
  input  logic               halt_on_err,
  input  logic               clear,
  output logic               locked,
  output logic               err_pulse,
  output logic               err_sticky,
  output logic [W-1:0]       expect_dat,
  output logic [CW-1:0]      match_cnt,
  output logic [CW-1:0]      err_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TRACK = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  p1, p0, p1_nxt, p0_nxt;
  logic          seeding, seeding_nxt;   // ONE was entered from EMPTY, not by resync
  logic          halted;
  logic          xfer, a_ok, b_ok, seed_ok, err_now;
  logic [1:0]    inc;
  logic [W-1:0]  sum_a, sum_b;
  logic [CW:0]   match_sum, err_sum;

  assign xfer  = sink.in_valid && !halted;
  assign sum_a = p1 + p0;
  assign sum_b = p0 + sink.in_a;
  assign a_ok  = (sink.in_a == sum_a);
  assign b_ok  = (sink.in_b == sum_b);

`ifdef FIB_CHECK_STRICT_SEED_EN
  assign seed_ok = (sink.in_a == W'(1)) && ((DUAL == 0) || (sink.in_b == W'(1)));
`else
  assign seed_ok = 1'b1;
`endif

  assign match_sum = {1'b0, match_cnt} + (CW+1)'(inc);
  assign err_sum   = {1'b0, err_cnt} + (CW+1)'(err_now);

  // State register; clear wins over any transfer in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       state <= EMPTY;
    else if (clear) state <= EMPTY;
    else            state <= state_nxt;
  end

  // Next state, next history, and per-beat match/error decisions.
  always_comb begin
    state_nxt   = state;
    p1_nxt      = p1;
    p0_nxt      = p0;
    seeding_nxt = seeding;
    err_now     = 1'b0;
    inc         = 2'd0;
    if (xfer) begin
      if (DUAL == 0) begin
        case (state)
          EMPTY: begin
            if (seed_ok) begin
              p0_nxt      = sink.in_a;
              seeding_nxt = 1'b1;
              state_nxt   = ONE;
            end else begin
              err_now = 1'b1;
            end
          end
          ONE: begin
            // Only the initial seed pair is restricted; a resync takes any value.
            if (seeding && !seed_ok) begin
              err_now     = 1'b1;
              p0_nxt      = '0;
              seeding_nxt = 1'b0;
              state_nxt   = EMPTY;
            end else begin
              p1_nxt      = p0;
              p0_nxt      = sink.in_a;
              seeding_nxt = 1'b0;
              state_nxt   = TRACK;
            end
          end
          TRACK: begin
            if (a_ok) begin
              inc    = 2'd1;
              p1_nxt = p0;
              p0_nxt = sink.in_a;
            end else begin
              err_now     = 1'b1;
              p0_nxt      = sink.in_a;
              seeding_nxt = 1'b0;
              state_nxt   = ONE;
            end
          end
          default: state_nxt = EMPTY;
        endcase
      end else begin
        case (state)
          EMPTY: begin
            if (seed_ok) begin
              p1_nxt    = sink.in_a;
              p0_nxt    = sink.in_b;
              state_nxt = TRACK;
            end else begin
              err_now = 1'b1;
            end
          end
          TRACK: begin
            inc     = {1'b0, a_ok} + {1'b0, b_ok};
            err_now = !(a_ok && b_ok);
            p1_nxt  = sink.in_a;
            p0_nxt  = sink.in_b;
          end
          default: state_nxt = EMPTY;
        endcase
      end
    end
  end

  // Sample history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1      <= '0;
      p0      <= '0;
      seeding <= 1'b0;
    end else if (clear) begin
      p1      <= '0;
      p0      <= '0;
      seeding <= 1'b0;
    end else begin
      p1      <= p1_nxt;
      p0      <= p0_nxt;
      seeding <= seeding_nxt;
    end
  end

  // Error flags, halt latch and saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      halted     <= 1'b0;
      match_cnt  <= '0;
      err_cnt    <= '0;
    end else if (clear) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      halted     <= 1'b0;
      match_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      err_pulse <= err_now;
      if (err_now) begin
        err_sticky <= 1'b1;
        if (halt_on_err) halted <= 1'b1;
      end
      match_cnt <= match_sum[CW] ? {CW{1'b1}} : match_sum[CW-1:0];
      err_cnt   <= err_sum[CW]   ? {CW{1'b1}} : err_sum[CW-1:0];
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    locked        = (state == TRACK);
    sink.in_ready = !halted;
    expect_dat    = sum_a;
  end

endmodule
